uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/dec2_to_bin.sv | 13 +
 rtl/uart_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART time/alarm command parser:
// state encoding, ASCII constants and error codes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    TERM,
    CHECK,
    REQ,
    ERR
  } state_t;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [1:0] E_CHAR    = 2'd1;
  localparam logic [1:0] E_RANGE   = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/dec2_to_bin.sv
// Two ASCII decimal digits (tens, units) to a 7-bit binary value.
// Inputs are already validated as '0'..'9', so the result is 0..99.
module dec2_to_bin
  import uart_cmd_pkg::*;
(
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  output logic [6:0] val
);

  assign val = 7'((hi - CH_0) * 8'd10 + (lo - CH_0));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses "T/A hhmmss CR" frames from a UART byte stream and issues
// a held set request to the clock core, with char/range/timeout errors.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       set_ack,
  output logic       set_req,
  output logic       set_target,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [5:0] set_ss,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic          tgt;
  logic [47:0]   digs;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [6:0]    hh;
  logic [6:0]    mm;
  logic [6:0]    ss;

  dec2_to_bin u_hh (.hi(digs[47:40]), .lo(digs[39:32]), .val(hh));
  dec2_to_bin u_mm (.hi(digs[31:24]), .lo(digs[23:16]), .val(mm));
  dec2_to_bin u_ss (.hi(digs[15:8]),  .lo(digs[7:0]),   .val(ss));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tgt        <= 1'b0;
      digs       <= '0;
      idx        <= '0;
      cnt        <= '0;
      set_req    <= 1'b0;
      set_target <= 1'b0;
      set_hh     <= '0;
      set_mm     <= '0;
      set_ss     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && (rx_byte == CH_T || rx_byte == CH_A)) begin
            state <= COLLECT;
            tgt   <= (rx_byte == CH_A);
            idx   <= '0;
            cnt   <= '0;
          end
        end
        COLLECT: begin
          // An arriving byte always beats a same-cycle timeout.
          if (rx_valid) begin
            cnt <= '0;
            if (is_digit(rx_byte)) begin
              digs <= {digs[39:0], rx_byte};
              idx  <= idx + 3'd1;
              if (idx == 3'd5) state <= TERM;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= E_CHAR;
            end
          end else if (cnt == LIM) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        TERM: begin
          if (rx_valid) begin
            cnt <= '0;
            if (rx_byte == CH_CR) begin
              state <= CHECK;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= E_CHAR;
            end
          end else if (cnt == LIM) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          if (hh > 7'd23 || mm > 7'd59 || ss > 7'd59) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= E_RANGE;
          end else begin
            set_hh     <= hh[4:0];
            set_mm     <= mm[5:0];
            set_ss     <= ss[5:0];
            set_target <= tgt;
            set_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (set_ack) begin
            set_req <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: good frames, range/char/timeout
// errors, reset mid-frame and bytes streamed while a request is held.
module tb_uart_cmd_ctrl;

  localparam int TO = 16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       set_ack;
  logic       set_req;
  logic       set_target;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .reset(reset),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .set_ack(set_ack),
    .set_req(set_req),
    .set_target(set_target),
    .set_hh(set_hh),
    .set_mm(set_mm),
    .set_ss(set_ss),
    .done(done),
    .err(err),
    .err_code(err_code),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic ack();
    set_ack = 1'b1;
    tick();
    set_ack = 1'b0;
  endtask

  int k;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    set_ack  = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_req", set_req, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_hh", set_hh, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

    // T123456 CR, ack 3 cycles after set_req
    send_str("T123456");
    send(8'h0D);
    chk("t1_check_noreq", set_req, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_req", set_req, 1);
    chk("t1_hh", set_hh, 12);
    chk("t1_mm", set_mm, 34);
    chk("t1_ss", set_ss, 56);
    chk("t1_tgt", set_target, 0);
    repeat (2) tick();
    chk("t1_req_hold", set_req, 1);
    ack();
    chk("t1_done", done, 1);
    chk("t1_req_off", set_req, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // set_ack outside REQ ignored
    ack();
    chk("ack_idle_done", done, 0);
    chk("ack_idle_busy", busy, 0);

    // Alarm frame at the range limits
    send_str("A235959");
    send(8'h0D);
    tick();
    chk("t2_req", set_req, 1);
    chk("t2_tgt", set_target, 1);
    chk("t2_hh", set_hh, 23);
    chk("t2_mm", set_mm, 59);
    chk("t2_ss", set_ss, 59);
    ack();
    chk("t2_done", done, 1);

    // Hours out of range
    send_str("T240000");
    send(8'h0D);
    tick();
    chk("t3_err", err, 1);
    chk("t3_code", err_code, 2);
    chk("t3_noreq", set_req, 0);
    chk("t3_hh_kept", set_hh, 23);
    tick();
    chk("t3_err_pulse", err, 0);
    chk("t3_idle", busy, 0);
    chk("t3_code_hold", err_code, 2);

    // Bad character, tail ignored, then a clean frame
    send_str("T12x");
    chk("t4_err", err, 1);
    chk("t4_code", err_code, 1);
    send_str("456");
    send(8'h0D);
    chk("t4_tail_idle", busy, 0);
    send_str("T000000");
    send(8'h0D);
    tick();
    chk("t4_req", set_req, 1);
    chk("t4_hh", set_hh, 0);
    chk("t4_ss", set_ss, 0);
    ack();

    // Inter-byte timeout
    send_str("T12");
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err) begin
        k = i;
        break;
      end
    end
    chk("t5_to_cycles", k, TO);
    chk("t5_code", err_code, 3);
    tick();
    chk("t5_idle", busy, 0);

    // Byte on the expiry cycle wins
    send_str("T12");
    repeat (TO - 1) tick();
    send(8'h33);
    chk("t6_no_err", err, 0);
    chk("t6_busy", busy, 1);
    send_str("456");
    send(8'h0D);
    tick();
    chk("t6_req", set_req, 1);
    chk("t6_hh", set_hh, 12);
    chk("t6_ss", set_ss, 56);
    ack();

    // Reset mid-frame
    send_str("T1234");
    chk("t7_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_hh", set_hh, 0);
    chk("t7_code", err_code, 0);
    tick();
    reset = 1'b0;
    tick();
    send_str("T010203");
    send(8'h0D);
    tick();
    chk("t7_req", set_req, 1);
    chk("t7_hh2", set_hh, 1);
    chk("t7_mm2", set_mm, 2);
    chk("t7_ss2", set_ss, 3);
    ack();

    // Bytes during REQ are dropped, outputs stable until ack
    send_str("T111111");
    send(8'h0D);
    tick();
    chk("t8_req", set_req, 1);
    send_str("A235959");
    send(8'h0D);
    repeat (12) tick();
    chk("t8_req_hold", set_req, 1);
    chk("t8_hh", set_hh, 11);
    chk("t8_mm", set_mm, 11);
    chk("t8_tgt", set_target, 0);
    ack();
    chk("t8_done", done, 1);
    tick();
    chk("t8_idle", busy, 0);
    chk("t8_noreq", set_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
